// File: rtl/i8088_bus_front_pkg.sv
// Shared types and constants for the 8088 bus front end.
package i8088_bus_pkg;
  localparam int CPU_AW = 20;
  localparam logic [31:0] MEM_BASE_DEF = 32'h4000_0000;
  localparam logic [31:0] IO_BASE_DEF  = 32'h4010_0000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    ISSUE_RD = 3'd2,
    ISSUE_WR = 3'd3,
    DRAIN    = 3'd4,
    HOLD     = 3'd5
  } state_e;
endpackage

// File: rtl/i8088_bus_front_if.sv
// Link between the bus front end (master) and the AXI capture block (slave).
// Handshake: a fetch is a level held high until axi_busy is seen high; the
// transaction is done when axi_busy falls, and read_data is valid at that point.
interface i8088_bus_front_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] A;
  logic [3:0]            wstrb;
  logic [31:0]           D;
  logic                  rdaddr_fetch;
  logic                  wraddr_fetch;
  logic                  wrdata_fetch;
  logic                  axi_busy;
  logic [7:0]            read_data;

  modport master (
    output A, wstrb, D, rdaddr_fetch, wraddr_fetch, wrdata_fetch,
    input  axi_busy, read_data
  );

  modport slave (
    input  A, wstrb, D, rdaddr_fetch, wraddr_fetch, wrdata_fetch,
    output axi_busy, read_data
  );
endinterface

// File: rtl/i8088_bus_front_sync2.sv
// Two-flop synchroniser / matched two-stage delay with a synchronous reset value.
module bus_sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/i8088_bus_front.sv
// 8088 local bus front end: syncs the CPU bus, issues capture-block fetches, drives READY.
// Optional macro I8088_IO_SPACE_EN maps I/O cycles to IO_BASE; otherwise I/O is answered locally.
module i8088_bus_front
  import i8088_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] MEM_BASE   = MEM_BASE_DEF,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEF,
  parameter int          WR_SETTLE  = 3
) (
  input  logic                       AXI_CLK,
  input  logic                       RESETN,
  input  logic                       CPU_ALE,
  input  logic                       CPU_RD_N,
  input  logic                       CPU_WR_N,
  input  logic                       CPU_IOM,
  input  logic [7:0]                 CPU_AD,
  input  logic [11:0]                CPU_A,
  output logic                       CPU_READY,
  output logic [7:0]                 CPU_D_OUT,
  output logic                       CPU_D_OE,
  i8088_bus_front_if.master          cap,
  output logic [2:0]                 o_dbg_state
);
  localparam int CNT_W = $clog2(WR_SETTLE) + 1;

  logic [3:0]          w_ctl_s;
  logic [CPU_AW-1:0]   w_bus_d;
  logic                w_ale_s, w_rd_n_s, w_wr_n_s, w_iom_s;
  logic [7:0]          w_ad_d;
  logic [CPU_AW:0]     r_addr_lat;
  logic                w_lat_io;
  logic [ADDR_WIDTH-1:0] w_map_addr;
  logic [3:0]          w_map_strb;
  logic                w_io_skip;

  state_e              r_state, w_state_nxt;
  logic                w_issue, w_issue_rd, w_cnt_load, w_cnt_dec, w_cap_d;
  logic                w_rd_done, w_io_rd, w_release;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_rd;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_d;
  logic                r_rd_fetch, r_wr_fetch, r_ready, r_d_oe;
  logic [7:0]          r_d_out;

  // Strobes idle high; the bus delay keeps address/data aligned with them.
  bus_sync2 #(.W(4), .RST_VAL(4'b0110)) u_sync_ctl (
    .clk(AXI_CLK), .rst_n(RESETN),
    .i_d({CPU_ALE, CPU_RD_N, CPU_WR_N, CPU_IOM}), .o_q(w_ctl_s)
  );
  bus_sync2 #(.W(CPU_AW), .RST_VAL('0)) u_dly_bus (
    .clk(AXI_CLK), .rst_n(RESETN), .i_d({CPU_A, CPU_AD}), .o_q(w_bus_d)
  );

  assign w_ale_s  = w_ctl_s[3];
  assign w_rd_n_s = w_ctl_s[2];
  assign w_wr_n_s = w_ctl_s[1];
  assign w_iom_s  = w_ctl_s[0];
  assign w_ad_d   = w_bus_d[7:0];

  always_ff @(posedge AXI_CLK) begin
    if (!RESETN)      r_addr_lat <= '0;
    else if (w_ale_s) r_addr_lat <= {w_iom_s, w_bus_d};
  end

  assign w_lat_io   = r_addr_lat[CPU_AW];
  assign w_map_addr = w_lat_io ? (ADDR_WIDTH'(IO_BASE) + ADDR_WIDTH'(r_addr_lat[15:0]))
                               : (ADDR_WIDTH'(MEM_BASE) + ADDR_WIDTH'(r_addr_lat[CPU_AW-1:0]));
  assign w_map_strb = 4'b0001 << w_map_addr[1:0];

`ifdef I8088_IO_SPACE_EN
  assign w_io_skip = 1'b0;
`else
  assign w_io_skip = w_lat_io;
`endif

  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_issue_rd  = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cap_d     = 1'b0;
    w_rd_done   = 1'b0;
    w_io_rd     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        // Read wins when both strobes are low; a busy capture block leaves the cycle pending.
        if (!w_rd_n_s) begin
          if (w_io_skip) begin
            w_state_nxt = HOLD;
            w_io_rd     = 1'b1;
          end else if (!cap.axi_busy) begin
            w_state_nxt = ISSUE_RD;
            w_issue     = 1'b1;
            w_issue_rd  = 1'b1;
          end
        end else if (!w_wr_n_s) begin
          if (w_io_skip) begin
            w_state_nxt = HOLD;
          end else if (!cap.axi_busy) begin
            w_state_nxt = SETTLE;
            w_issue     = 1'b1;
            w_cnt_load  = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          w_cap_d     = 1'b1;
          w_state_nxt = ISSUE_WR;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ISSUE_RD, ISSUE_WR: if (cap.axi_busy) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!cap.axi_busy) begin
          w_state_nxt = HOLD;
          w_rd_done   = r_is_rd;
        end
      end
      HOLD: begin
        if (w_rd_n_s && w_wr_n_s) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      r_a        <= '0;
      r_wstrb    <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_is_rd    <= 1'b0;
      r_rd_fetch <= 1'b0;
      r_wr_fetch <= 1'b0;
      r_ready    <= 1'b0;
      r_d_out    <= 8'hFF;
      r_d_oe     <= 1'b0;
    end else begin
      if (w_issue) begin
        r_a     <= w_map_addr;
        r_wstrb <= w_map_strb;
        r_is_rd <= w_issue_rd;
      end
      if (w_cnt_load)     r_cnt <= CNT_W'(WR_SETTLE - 1);
      else if (w_cnt_dec) r_cnt <= r_cnt - CNT_W'(1);
      if (w_cap_d) r_d <= {4{w_ad_d}};
      if (w_rd_done) begin
        r_d_out <= cap.read_data;
        r_d_oe  <= 1'b1;
      end else if (w_io_rd) begin
        r_d_out <= 8'hFF;
        r_d_oe  <= 1'b1;
      end else if (w_release) begin
        r_d_oe  <= 1'b0;
      end
      // Outputs registered from the next state so they change together with it.
      r_rd_fetch <= (w_state_nxt == ISSUE_RD);
      r_wr_fetch <= (w_state_nxt == ISSUE_WR);
      r_ready    <= (w_state_nxt == HOLD);
    end
  end

  assign cap.A            = r_a;
  assign cap.wstrb        = r_wstrb;
  assign cap.D            = r_d;
  assign cap.rdaddr_fetch = r_rd_fetch;
  assign cap.wraddr_fetch = r_wr_fetch;
  assign cap.wrdata_fetch = r_wr_fetch;
  assign CPU_READY        = r_ready;
  assign CPU_D_OUT        = r_d_out;
  assign CPU_D_OE         = r_d_oe;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_i8088_bus_front.sv
// Directed bench for i8088_bus_front; expected values are hand-computed from the bus timing.
module tb_i8088_bus_front;
  import i8088_bus_pkg::*;

  logic        clk;
  logic        rstn;
  logic        ale, rd_n, wr_n, iom;
  logic [7:0]  cpu_ad;
  logic [11:0] cpu_a;
  logic        ready, d_oe;
  logic [7:0]  d_out;
  logic [2:0]  dbg_state;
  int          checks;
  int          failures;

  i8088_bus_front_if #(.ADDR_WIDTH(32)) cap_if ();

  i8088_bus_front dut (
    .AXI_CLK(clk), .RESETN(rstn), .CPU_ALE(ale), .CPU_RD_N(rd_n), .CPU_WR_N(wr_n),
    .CPU_IOM(iom), .CPU_AD(cpu_ad), .CPU_A(cpu_a), .CPU_READY(ready),
    .CPU_D_OUT(d_out), .CPU_D_OE(d_oe), .cap(cap_if), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic addr_phase(input logic io, input logic [19:0] adr);
    iom    = io;
    cpu_a  = adr[19:8];
    cpu_ad = adr[7:0];
    ale    = 1'b1;
    tick(2);
    ale    = 1'b0;
    tick(1);
  endtask

  task automatic chk_fetch(input string tag, input logic rd_f, input logic wr_f);
    chk({tag, "_rdaddr"}, 32'(cap_if.rdaddr_fetch), 32'(rd_f));
    chk({tag, "_wraddr"}, 32'(cap_if.wraddr_fetch), 32'(wr_f));
    chk({tag, "_wrdata"}, 32'(cap_if.wrdata_fetch), 32'(wr_f));
  endtask

  initial begin
    int seen;
    checks = 0;
    failures = 0;
    ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; iom = 1'b0;
    cpu_ad = 8'h00; cpu_a = 12'h000;
    cap_if.axi_busy = 1'b0; cap_if.read_data = 8'h00;
    rstn = 1'b0;
    tick(3);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_doe", 32'(d_oe), 32'd0);
    chk("rst_dout", 32'(d_out), 32'hFF);
    chk("rst_a", cap_if.A, 32'h0);
    chk("rst_wstrb", 32'(cap_if.wstrb), 32'h0);
    chk("rst_d", cap_if.D, 32'h0);
    chk_fetch("rst", 1'b0, 1'b0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rstn = 1'b1;
    tick(1);

    // memory read at 12345 returning A5
    addr_phase(1'b0, 20'h12345);
    rd_n = 1'b0;
    tick(2);
    chk_fetch("rd1_early", 1'b0, 1'b0);
    tick(1);
    chk_fetch("rd1_issue", 1'b1, 1'b0);
    chk("rd1_a", cap_if.A, 32'h4001_2345);
    chk("rd1_wstrb", 32'(cap_if.wstrb), 32'h2);
    chk("rd1_ready_lo", 32'(ready), 32'd0);
    tick(1);
    chk("rd1_fetch_hold", 32'(cap_if.rdaddr_fetch), 32'd1);
    cap_if.axi_busy = 1'b1;
    tick(1);
    chk_fetch("rd1_drain", 1'b0, 1'b0);
    cap_if.read_data = 8'hA5;
    tick(3);
    chk("rd1_ready_drain", 32'(ready), 32'd0);
    cap_if.axi_busy = 1'b0;
    tick(1);
    chk("rd1_ready", 32'(ready), 32'd1);
    chk("rd1_dout", 32'(d_out), 32'hA5);
    chk("rd1_doe", 32'(d_oe), 32'd1);
    tick(3);
    chk("rd1_ready_held", 32'(ready), 32'd1);
    rd_n = 1'b1;
    tick(3);
    chk("rd1_ready_rel", 32'(ready), 32'd0);
    chk("rd1_doe_rel", 32'(d_oe), 32'd0);

    // memory write 3C to FFFFF
    addr_phase(1'b0, 20'hFFFFF);
    cpu_ad = 8'h3C;
    wr_n = 1'b0;
    tick(5);
    chk_fetch("wr1_settle", 1'b0, 1'b0);
    tick(1);
    chk_fetch("wr1_issue", 1'b0, 1'b1);
    chk("wr1_d", cap_if.D, 32'h3C3C_3C3C);
    chk("wr1_a", cap_if.A, 32'h400F_FFFF);
    chk("wr1_wstrb", 32'(cap_if.wstrb), 32'h8);
    cap_if.axi_busy = 1'b1;
    tick(2);
    chk_fetch("wr1_drain", 1'b0, 1'b0);
    chk("wr1_ready_drain", 32'(ready), 32'd0);
    cap_if.axi_busy = 1'b0;
    tick(1);
    chk("wr1_ready", 32'(ready), 32'd1);
    chk("wr1_doe", 32'(d_oe), 32'd0);
    wr_n = 1'b1;
    tick(3);
    chk("wr1_ready_rel", 32'(ready), 32'd0);

    // capture block busy for 50 cycles before the read may issue
    cap_if.axi_busy = 1'b1;
    addr_phase(1'b0, 20'h00100);
    rd_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 47; i++) begin
      tick(1);
      if (cap_if.rdaddr_fetch || cap_if.wraddr_fetch || ready) seen++;
    end
    chk("busy_blocked", 32'(seen), 32'd0);
    cap_if.axi_busy = 1'b0;
    tick(1);
    chk("busy_issue", 32'(cap_if.rdaddr_fetch), 32'd1);
    chk("busy_a", cap_if.A, 32'h4000_0100);
    chk("busy_wstrb", 32'(cap_if.wstrb), 32'h1);
    cap_if.axi_busy = 1'b1;
    tick(1);
    cap_if.read_data = 8'h5A;
    cap_if.axi_busy = 1'b0;
    tick(1);
    chk("busy_dout", 32'(d_out), 32'h5A);
    chk("busy_ready", 32'(ready), 32'd1);
    rd_n = 1'b1;
    tick(3);

    // both strobes low: read wins; then reset during DRAIN
    addr_phase(1'b0, 20'h00002);
    rd_n = 1'b0;
    wr_n = 1'b0;
    tick(3);
    chk_fetch("both", 1'b1, 1'b0);
    chk("both_wstrb", 32'(cap_if.wstrb), 32'h4);
    cap_if.axi_busy = 1'b1;
    tick(1);
    chk("both_state", 32'(dbg_state), 32'(DRAIN));
    rstn = 1'b0;
    rd_n = 1'b1;
    wr_n = 1'b1;
    tick(1);
    chk_fetch("mrst", 1'b0, 1'b0);
    chk("mrst_ready", 32'(ready), 32'd0);
    chk("mrst_doe", 32'(d_oe), 32'd0);
    chk("mrst_a", cap_if.A, 32'h0);
    chk("mrst_state", 32'(dbg_state), 32'(IDLE));
    rstn = 1'b1;
    cap_if.axi_busy = 1'b0;
    tick(2);
    addr_phase(1'b0, 20'h00003);
    rd_n = 1'b0;
    tick(3);
    chk("post_issue", 32'(cap_if.rdaddr_fetch), 32'd1);
    chk("post_a", cap_if.A, 32'h4000_0003);
    cap_if.axi_busy = 1'b1;
    tick(1);
    cap_if.read_data = 8'h77;
    cap_if.axi_busy = 1'b0;
    tick(1);
    chk("post_ready", 32'(ready), 32'd1);
    chk("post_dout", 32'(d_out), 32'h77);
    rd_n = 1'b1;
    tick(3);

    // strobe released early: one HOLD cycle, no re-issue
    addr_phase(1'b0, 20'h00040);
    rd_n = 1'b0;
    tick(3);
    chk("early_issue", 32'(cap_if.rdaddr_fetch), 32'd1);
    cap_if.axi_busy = 1'b1;
    tick(1);
    rd_n = 1'b1;
    tick(3);
    cap_if.read_data = 8'h42;
    cap_if.axi_busy = 1'b0;
    tick(1);
    chk("early_ready", 32'(ready), 32'd1);
    chk("early_dout", 32'(d_out), 32'h42);
    tick(1);
    chk("early_ready_rel", 32'(ready), 32'd0);
    chk("early_doe_rel", 32'(d_oe), 32'd0);
    tick(3);
    chk_fetch("early_noreissue", 1'b0, 1'b0);

    // I/O write to 03F8 and I/O read
    addr_phase(1'b1, 20'h003F8);
    cpu_ad = 8'h11;
    wr_n = 1'b0;
`ifdef I8088_IO_SPACE_EN
    tick(6);
    chk_fetch("iowr_issue", 1'b0, 1'b1);
    chk("iowr_a", cap_if.A, 32'h4010_03F8);
    chk("iowr_d", cap_if.D, 32'h1111_1111);
    cap_if.axi_busy = 1'b1;
    tick(1);
    cap_if.axi_busy = 1'b0;
    tick(1);
    chk("iowr_ready", 32'(ready), 32'd1);
`else
    tick(3);
    chk("iowr_ready", 32'(ready), 32'd1);
    chk_fetch("iowr_nofetch", 1'b0, 1'b0);
`endif
    wr_n = 1'b1;
    tick(3);
    chk("iowr_ready_rel", 32'(ready), 32'd0);

    addr_phase(1'b1, 20'h00060);
    rd_n = 1'b0;
`ifdef I8088_IO_SPACE_EN
    tick(3);
    chk("iord_issue", 32'(cap_if.rdaddr_fetch), 32'd1);
    chk("iord_a", cap_if.A, 32'h4010_0060);
    cap_if.axi_busy = 1'b1;
    tick(1);
    cap_if.read_data = 8'hFF;
    cap_if.axi_busy = 1'b0;
    tick(1);
`else
    tick(3);
    chk_fetch("iord_nofetch", 1'b0, 1'b0);
`endif
    chk("iord_ready", 32'(ready), 32'd1);
    chk("iord_dout", 32'(d_out), 32'hFF);
    chk("iord_doe", 32'(d_oe), 32'd1);
    rd_n = 1'b1;
    tick(3);
    chk("iord_ready_rel", 32'(ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
